// File: rtl/array_arbiter2_pkg.sv
// rtl/array_arbiter2_pkg.sv - shared constants and types for the two-requester array arbiter
//
// Purpose: default address/data widths, requester index encoding used by the
// round-robin priority register, and the array port bundle type.
package array_arbiter2_pkg;

  // Default widths of the shared array (address / data).
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // Requester indices; also the encoding of the priority register.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Command side of the single array port at default widths.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] di;
    logic              we;
  } arr_cmd_t;

endpackage

// File: rtl/array_arbiter2_if.sv
// rtl/array_arbiter2_if.sv - requester command/response channel of the array arbiter
//
// Purpose: one requester's view of the shared array.
//   addr/di/we/valid/ready : command channel (valid/ready handshake)
//   do_data/do_valid/do_ready : read response channel (valid/ready handshake)
// Modports: master = requester side, slave = arbiter side.
interface array_arbiter2_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic          we;
  logic          valid;
  logic          ready;
  logic [DW-1:0] do_data;
  logic          do_valid;
  logic          do_ready;

  modport master (
    output addr, di, we, valid, do_ready,
    input  ready, do_data, do_valid
  );

  modport slave (
    input  addr, di, we, valid, do_ready,
    output ready, do_data, do_valid
  );

endinterface

// File: rtl/array_arb_resp.sv
// rtl/array_arb_resp.sv - per-requester read pipeline flag and response register
//
// Purpose: tracks one read in flight and holds its data until consumed.
// Ports:
//   clk, nrst   : clock, synchronous active-low reset
//   issue       : a read for this requester was granted this cycle
//   arr_do      : array read data (valid the cycle after the grant)
//   do_ready    : response consumed
//   pend        : read in flight (array data arrives this cycle)
//   do_data     : held read data
//   do_valid    : read data valid
module array_arb_resp #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          issue,
  input  logic [DW-1:0] arr_do,
  input  logic          do_ready,
  output logic          pend,
  output logic [DW-1:0] do_data,
  output logic          do_valid
);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pend     <= 1'b0;
      do_data  <= '0;
      do_valid <= 1'b0;
    end else begin
      // The arbiter never grants while pend or do_valid is set, so a
      // new issue can never collide with a capture or a held response.
      pend <= issue;
      if (pend) begin
        do_data  <= arr_do;
        do_valid <= 1'b1;
      end else if (do_valid && do_ready) begin
        do_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/array_arbiter2.sv
// rtl/array_arbiter2.sv - round-robin arbiter sharing one array port between two requesters
//
// Purpose: grants at most one command per cycle to the array, alternating
// priority after every grant, and returns read data per requester.
// Ports:
//   clk, nrst          : clock, synchronous active-low reset
//   r0, r1             : requester channels (array_arbiter2_if.slave)
//   arr_addr/di/we     : array command port (zero when nothing is granted)
//   arr_do             : array read data, one cycle after the address
module array_arbiter2
  import array_arbiter2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  array_arbiter2_if.slave r0,
  array_arbiter2_if.slave r1,
  output logic [AW-1:0]   arr_addr,
  output logic [DW-1:0]   arr_di,
  output logic            arr_we,
  input  logic [DW-1:0]   arr_do
);

  logic prio;
  logic pend0, pend1;
  logic elig0, elig1;
  logic grant0, grant1;

  // Waiting for an own outstanding read (or its undrained response) also
  // blocks writes, which keeps each requester's commands in order.
  assign elig0 = r0.valid && !pend0 && !r0.do_valid;
  assign elig1 = r1.valid && !pend1 && !r1.do_valid;

  assign grant0 = elig0 && (!elig1 || prio == REQ0);
  assign grant1 = elig1 && (!elig0 || prio == REQ1);

  assign r0.ready = grant0;
  assign r1.ready = grant1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      prio <= REQ0;
    end else if (grant0) begin
      prio <= REQ1;
    end else if (grant1) begin
      prio <= REQ0;
    end
  end

  always_comb begin
    arr_addr = '0;
    arr_di   = '0;
    arr_we   = 1'b0;
    if (grant0) begin
      arr_addr = r0.addr;
      arr_di   = r0.di;
      arr_we   = r0.we;
    end else if (grant1) begin
      arr_addr = r1.addr;
      arr_di   = r1.di;
      arr_we   = r1.we;
    end
  end

  array_arb_resp #(.DW(DW)) u_resp0 (
    .clk      (clk),
    .nrst     (nrst),
    .issue    (grant0 && !r0.we),
    .arr_do   (arr_do),
    .do_ready (r0.do_ready),
    .pend     (pend0),
    .do_data  (r0.do_data),
    .do_valid (r0.do_valid)
  );

  array_arb_resp #(.DW(DW)) u_resp1 (
    .clk      (clk),
    .nrst     (nrst),
    .issue    (grant1 && !r1.we),
    .arr_do   (arr_do),
    .do_ready (r1.do_ready),
    .pend     (pend1),
    .do_data  (r1.do_data),
    .do_valid (r1.do_valid)
  );

endmodule

// File: tb/tb_array_arbiter2.sv
// tb/tb_array_arbiter2.sv - self-checking bench for array_arbiter2
module tb_array_arbiter2;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] arr_addr;
  logic [7:0] arr_di;
  logic       arr_we;
  logic [7:0] arr_do;
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int cnt0, cnt1;
  logic exp_g0;

  array_arbiter2_if #(.AW(8), .DW(8)) r0_if ();
  array_arbiter2_if #(.AW(8), .DW(8)) r1_if ();

  array_arbiter2 #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .r0       (r0_if),
    .r1       (r1_if),
    .arr_addr (arr_addr),
    .arr_di   (arr_di),
    .arr_we   (arr_we),
    .arr_do   (arr_do)
  );

  always #5 clk = ~clk;

  // Behavioural single-port array: write at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_di;
    arr_do <= mem[arr_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic [7:0] a,
                       input logic [7:0] d, input logic w);
    if (n == 0) begin
      r0_if.valid = v; r0_if.addr = a; r0_if.di = d; r0_if.we = w;
    end else begin
      r1_if.valid = v; r1_if.addr = a; r1_if.di = d; r1_if.we = w;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) step();
    check_eq("drain_q0", q0.size(), 0);
    check_eq("drain_q1", q1.size(), 0);
  endtask

  // Response scoreboard: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && r0_if.do_valid && r0_if.do_ready) begin
      if (q0.size() == 0) check_eq("r0_unexp", r0_if.do_valid, 0);
      else check_eq("r0_do", r0_if.do_data, q0.pop_front());
    end
    if (nrst && r1_if.do_valid && r1_if.do_ready) begin
      if (q1.size() == 0) check_eq("r1_unexp", r1_if.do_valid, 0);
      else check_eq("r1_do", r1_if.do_data, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    idle();
    r0_if.do_ready = 1'b1;
    r1_if.do_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check_eq("rst_v0", r0_if.do_valid, 0);
    check_eq("rst_d0", r0_if.do_data, 0);
    check_eq("rst_v1", r1_if.do_valid, 0);
    check_eq("rst_d1", r1_if.do_data, 0);
    check_eq("rst_we", arr_we, 0);
    nrst = 1'b1;
    step();

    // Write then read back on r0.
    drive(0, 1'b1, 8'd5, 8'h2A, 1'b1);
    @(negedge clk);
    check_eq("wr_rdy", r0_if.ready, 1);
    check_eq("wr_we", arr_we, 1);
    check_eq("wr_addr", arr_addr, 5);
    check_eq("wr_di", arr_di, 8'h2A);
    step();
    drive(0, 1'b1, 8'd5, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("rd_rdy", r0_if.ready, 1);
    check_eq("rd_we", arr_we, 0);
    step();
    q0.push_back(8'h2A);
    idle();
    @(negedge clk);
    check_eq("lat1_v0", r0_if.do_valid, 0);
    step();
    @(negedge clk);
    check_eq("lat2_v0", r0_if.do_valid, 1);
    step();

    // Simultaneous first reads after reset.
    drive(0, 1'b1, 8'd1, 8'h11, 1'b1);
    step();
    drive(0, 1'b1, 8'd2, 8'h22, 1'b1);
    step();
    idle();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    drive(0, 1'b1, 8'd1, 8'h00, 1'b0);
    drive(1, 1'b1, 8'd2, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("sim_g0", r0_if.ready, 1);
    check_eq("sim_ng1", r1_if.ready, 0);
    check_eq("sim_addr0", arr_addr, 1);
    step();
    q0.push_back(8'h11);
    drive(0, 1'b0, 8'd0, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("sim_g1", r1_if.ready, 1);
    check_eq("sim_addr1", arr_addr, 2);
    step();
    q1.push_back(8'h22);
    idle();
    @(negedge clk);
    check_eq("sim_t2_v0", r0_if.do_valid, 1);
    check_eq("sim_t2_v1", r1_if.do_valid, 0);
    step();
    @(negedge clk);
    check_eq("sim_t3_v1", r1_if.do_valid, 1);
    check_eq("sim_t3_v0", r0_if.do_valid, 0);
    step();

    // Fairness: both requesters write continuously.
    cnt0 = 0;
    cnt1 = 0;
    drive(0, 1'b1, 8'd10, 8'hA0, 1'b1);
    drive(1, 1'b1, 8'd20, 8'hB0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g0 = (i % 2 == 0);
      check_eq("fair_g0", r0_if.ready, exp_g0);
      check_eq("fair_g1", r1_if.ready, !exp_g0);
      if (r0_if.ready) cnt0++;
      if (r1_if.ready) cnt1++;
      step();
    end
    idle();
    check_eq("fair_cnt0", cnt0, 4);
    check_eq("fair_cnt1", cnt1, 4);

    // Backpressure on r0's response while r1 keeps writing.
    r0_if.do_ready = 1'b0;
    drive(0, 1'b1, 8'd5, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("bp_g0", r0_if.ready, 1);
    step();
    q0.push_back(8'h2A);
    drive(1, 1'b1, 8'd30, 8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_r0_rdy", r0_if.ready, 0);
      check_eq("bp_g1", r1_if.ready, 1);
      if (i >= 1) begin
        check_eq("bp_v0", r0_if.do_valid, 1);
        check_eq("bp_d0", r0_if.do_data, 8'h2A);
      end
      step();
    end
    idle();
    r0_if.do_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_pre_v0", r0_if.do_valid, 1);
    step();
    @(negedge clk);
    check_eq("bp_drained", r0_if.do_valid, 0);
    check_eq("bp_q0", q0.size(), 0);
    step();

    // Same-cycle hazard: r0 writes, r1 reads the same address.
    drive(0, 1'b1, 8'd3, 8'h07, 1'b1);
    drive(1, 1'b1, 8'd3, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("hz_g0", r0_if.ready, 1);
    check_eq("hz_ng1", r1_if.ready, 0);
    step();
    drive(0, 1'b0, 8'd0, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("hz_g1", r1_if.ready, 1);
    check_eq("hz_we", arr_we, 0);
    step();
    q1.push_back(8'h07);
    idle();
    wait_drained();

    // Reset the cycle after an r1 read grant, with r0 granted at the reset edge.
    drive(1, 1'b1, 8'd2, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("mr_g1", r1_if.ready, 1);
    step();
    drive(1, 1'b0, 8'd0, 8'h00, 1'b0);
    drive(0, 1'b1, 8'd40, 8'h55, 1'b1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mr_nov1", r1_if.do_valid, 0);
      step();
    end
    drive(0, 1'b1, 8'd41, 8'h01, 1'b1);
    drive(1, 1'b1, 8'd42, 8'h02, 1'b1);
    @(negedge clk);
    check_eq("mr_g0", r0_if.ready, 1);
    check_eq("mr_ng1", r1_if.ready, 0);
    step();
    idle();
    wait_drained();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
